// File: rtl/mi_pkg.sv
// ============================================================================
// mi_pkg : state type, RV32I field constants and LW/SW encoders for mi_expander
// Rev 1.0
// ============================================================================
`default_nettype none

package mi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } state_t;

  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [2:0]  F3_WORD   = 3'b010;
  localparam logic [2:0]  F3_MEMCPY = 3'b000;
  localparam logic [2:0]  F3_MEMSET = 3'b001;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  function automatic logic [31:0] enc_lw(input logic [11:0] off,
                                         input logic [4:0]  rs1,
                                         input logic [4:0]  rd);
    return {off, rs1, F3_WORD, rd, OP_LOAD};
  endfunction

  function automatic logic [31:0] enc_sw(input logic [11:0] off,
                                         input logic [4:0]  rs2,
                                         input logic [4:0]  rs1);
    return {off[11:5], rs2, rs1, F3_WORD, off[4:0], OP_STORE};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mi_expander.sv
// ============================================================================
// mi_expander : expands MEMCPY/MEMSET macros into LW/SW micro-ops, passes
//               every other instruction through one registered stage.
// Rev 1.0
// ============================================================================
`default_nettype none

module mi_expander
  import mi_pkg::*;
#(
  parameter int         WIDTH         = 32,
  parameter int         MAX_WORDS     = 512,
  parameter logic [4:0] SCRATCH_REG   = 5'd9,
  parameter logic [6:0] CUSTOM_OPCODE = 7'b0001011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] instr_in,
  output logic             pc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] instr_out,
  output logic [WIDTH-1:0] pc_out,
  output logic             uop_last,
  output logic             busy,
  output logic [1:0]       state
);

  localparam int          IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [11:0] MAX_N = 12'(MAX_WORDS);

  state_t             r_state, w_state;
  logic [IDX_W-1:0]   r_idx, w_idx;
  logic [IDX_W-1:0]   r_last, w_last;
  logic [4:0]         r_src, w_src;
  logic [4:0]         r_data, w_data;
  logic [4:0]         r_dst, w_dst;
  logic               r_memcpy, w_memcpy;
  logic               w_out_valid, w_uop_last;
  logic [WIDTH-1:0]   w_instr, w_pc;

  logic               w_advance;
  logic [6:0]         w_opc;
  logic [2:0]         w_f3;
  logic [11:0]        w_n_raw, w_n_eff;
  logic               w_is_memcpy, w_is_memset;
  logic [IDX_W-1:0]   w_idx_inc;
  logic [11:0]        w_off_cur, w_off_nxt;

  assign w_advance   = !out_valid || out_ready;
  assign in_ready    = (r_state == IDLE) && w_advance && !flush;
  assign pc_en       = in_ready;
  assign busy        = (r_state != IDLE);
  assign state       = r_state;

  assign w_opc       = instr_in[6:0];
  assign w_f3        = instr_in[14:12];
  assign w_n_raw     = instr_in[31:20];
  assign w_n_eff     = (w_n_raw > MAX_N) ? MAX_N : w_n_raw;
  assign w_is_memcpy = (w_opc == CUSTOM_OPCODE) && (w_f3 == F3_MEMCPY);
  assign w_is_memset = (w_opc == CUSTOM_OPCODE) && (w_f3 == F3_MEMSET);

  // Word offsets are idx*4; the clamp keeps them inside the 12-bit immediate.
  assign w_idx_inc   = r_idx + IDX_W'(1);
  assign w_off_cur   = 12'({r_idx, 2'b00});
  assign w_off_nxt   = 12'({w_idx_inc, 2'b00});

  always_comb begin
    w_state     = r_state;
    w_out_valid = out_valid;
    w_instr     = instr_out;
    w_pc        = pc_out;
    w_uop_last  = uop_last;
    w_idx       = r_idx;
    w_last      = r_last;
    w_src       = r_src;
    w_data      = r_data;
    w_dst       = r_dst;
    w_memcpy    = r_memcpy;

    if (flush) begin
      w_state     = IDLE;
      w_out_valid = 1'b0;
      w_idx       = '0;
    end else if (w_advance) begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            w_out_valid = 1'b1;
            w_pc        = pc_in;
            w_idx       = '0;
            if (!(w_is_memcpy || w_is_memset)) begin
              w_instr    = instr_in;
              w_uop_last = 1'b1;
            end else if (w_n_eff == 12'd0) begin
              w_instr    = WIDTH'(NOP_INSTR);
              w_uop_last = 1'b1;
            end else begin
              w_src    = instr_in[19:15];
              w_data   = w_is_memcpy ? SCRATCH_REG : instr_in[19:15];
              w_dst    = instr_in[11:7];
              w_memcpy = w_is_memcpy;
              w_last   = IDX_W'(w_n_eff - 12'd1);
              if (w_is_memcpy) begin
                w_instr    = WIDTH'(enc_lw(12'd0, instr_in[19:15], SCRATCH_REG));
                w_uop_last = 1'b0;
                w_state    = LOAD;
              end else begin
                w_instr    = WIDTH'(enc_sw(12'd0, instr_in[19:15], instr_in[11:7]));
                w_uop_last = (w_n_eff == 12'd1);
                w_state    = STORE;
              end
            end
          end else begin
            w_out_valid = 1'b0;
          end
        end
        LOAD: begin
          w_instr    = WIDTH'(enc_sw(w_off_cur, r_data, r_dst));
          w_uop_last = (r_idx == r_last);
          w_state    = STORE;
        end
        STORE: begin
          if (r_idx == r_last) begin
            w_out_valid = 1'b0;
            w_idx       = '0;
            w_state     = IDLE;
          end else begin
            w_idx = w_idx_inc;
            if (r_memcpy) begin
              w_instr    = WIDTH'(enc_lw(w_off_nxt, r_src, SCRATCH_REG));
              w_uop_last = 1'b0;
              w_state    = LOAD;
            end else begin
              w_instr    = WIDTH'(enc_sw(w_off_nxt, r_data, r_dst));
              w_uop_last = (w_idx_inc == r_last);
              w_state    = STORE;
            end
          end
        end
        default: begin
          w_state     = IDLE;
          w_out_valid = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      out_valid <= 1'b0;
      instr_out <= WIDTH'(NOP_INSTR);
      pc_out    <= '0;
      uop_last  <= 1'b0;
      r_idx     <= '0;
      r_last    <= '0;
      r_src     <= '0;
      r_data    <= '0;
      r_dst     <= '0;
      r_memcpy  <= 1'b0;
    end else begin
      r_state   <= w_state;
      out_valid <= w_out_valid;
      instr_out <= w_instr;
      pc_out    <= w_pc;
      uop_last  <= w_uop_last;
      r_idx     <= w_idx;
      r_last    <= w_last;
      r_src     <= w_src;
      r_data    <= w_data;
      r_dst     <= w_dst;
      r_memcpy  <= w_memcpy;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mi_expander.sv
// ============================================================================
// tb_mi_expander : directed and randomized checks of mi_expander against a
//                  beat-list model of macro expansion.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mi_expander;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] pc_in, instr_in;
  logic        in_ready, pc_en, out_valid, uop_last, busy;
  logic [31:0] instr_out, pc_out;
  logic [1:0]  state;

  always #5 clk = ~clk;

  mi_expander dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pc_in     (pc_in),
    .instr_in  (instr_in),
    .pc_en     (pc_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr_out (instr_out),
    .pc_out    (pc_out),
    .uop_last  (uop_last),
    .busy      (busy),
    .state     (state)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        last;
    logic [1:0]  kind;   // 0 pass/NOP, 1 LW, 2 SW of a macro
  } beat_t;

  beat_t       q[$];
  logic [31:0] got[$];
  int          vectors     = 0;
  int          miscompares = 0;
  bit          chk_en      = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_macro(input logic [31:0] ins);
    return (ins[6:0] == 7'h0B) && (ins[14:12] <= 3'd1);
  endfunction

  function automatic int word_count(input logic [31:0] ins);
    int n;
    n = int'(ins[31:20]);
    return (n > 512) ? 512 : n;
  endfunction

  function automatic int n_beats(input logic [31:0] ins);
    if (!is_macro(ins) || word_count(ins) == 0) return 1;
    return ins[12] ? word_count(ins) : 2 * word_count(ins);
  endfunction

  // j-th output beat produced by instruction ins fetched at pc
  function automatic beat_t beat(input logic [31:0] ins, input logic [31:0] pc, input int j);
    beat_t       b;
    int          n, i;
    logic [31:0] off, src, dst, data;
    b.pc = pc; b.kind = 2'd0; b.last = 1'b1; b.instr = ins;
    if (is_macro(ins)) begin
      n = word_count(ins);
      if (n == 0) begin
        b.instr = 32'h00000013;
      end else begin
        src  = 32'(ins[19:15]);
        dst  = 32'(ins[11:7]);
        i    = ins[12] ? j : j / 2;
        off  = 32'(4 * i);
        data = ins[12] ? src : 32'd9;
        if (!ins[12] && (j % 2 == 0)) begin
          b.kind  = 2'd1;
          b.last  = 1'b0;
          b.instr = (off << 20) | (src << 15) | (32'd2 << 12) | (32'd9 << 7) | 32'd3;
        end else begin
          b.kind  = 2'd2;
          b.last  = (i == n - 1);
          b.instr = ((off >> 5) << 25) | (data << 20) | (dst << 15) | (32'd2 << 12)
                  | ((off & 32'd31) << 7) | 32'h23;
        end
      end
    end
    return b;
  endfunction

  // Per-cycle comparison against the model, then advance the model across the edge
  always @(negedge clk) begin
    bit exp_ir;
    int nb;
    if (chk_en) begin
      exp_ir = !flush && (q.size() == 0 || (q.size() == 1 && q[0].kind == 2'd0 && out_ready));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("instr_out", instr_out, q[0].instr);
        chk("pc_out", pc_out, q[0].pc);
        chk("uop_last", 32'(uop_last), 32'(q[0].last));
        chk("state", 32'(state), 32'(q[0].kind));
        chk("busy", 32'(busy), 32'(q[0].kind != 2'd0));
      end else begin
        chk("state_idle", 32'(state), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
      end
      chk("in_ready", 32'(in_ready), 32'(exp_ir));
      chk("pc_en", 32'(pc_en), 32'(exp_ir));
      if (out_valid && out_ready) got.push_back(instr_out);
      if (rst || flush) begin
        q.delete();
      end else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (in_valid && exp_ir) begin
          nb = n_beats(instr_in);
          for (int j = 0; j < nb; j++) q.push_back(beat(instr_in, pc_in, j));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    instr_in = ins;
    pc_in    = pc;
    for (int k = 0; k < 200 && !done; k++) begin
      #2;
      done = in_ready;
      step();
    end
    in_valid = 1'b0;
    chk("send_accept", 32'(done), 32'd1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [11:0] n;
    logic [2:0]  f3;
    int          sel;
    r   = $urandom;
    sel = $urandom_range(0, 49);
    if (sel < 15) return r;
    n  = (sel == 49) ? 12'($urandom_range(500, 700)) : 12'($urandom_range(0, 5));
    f3 = (sel % 4 < 2) ? 3'b000 : (sel % 4 == 2) ? 3'b001 : 3'($urandom_range(2, 7));
    return {n, r[19:15], f3, r[11:7], 7'b0001011};
  endfunction

  initial begin
    beat_t b;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    pc_in = '0; instr_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_instr_out", instr_out, 32'h00000013);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_uop_last", 32'(uop_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    step();

    // model pins
    b = beat(32'h0025058B, 32'h200, 0); chk("model_lw0", b.instr, 32'h00052483);
    b = beat(32'h0025058B, 32'h200, 1); chk("model_sw0", b.instr, 32'h0095A023);
    b = beat(32'h0025058B, 32'h200, 3); chk("model_sw1", b.instr, 32'h0095A223);
    b = beat(32'h0032930B, 32'h400, 2); chk("model_ms2", b.instr, 32'h00532423);
    b = beat(32'h3E85058B, 32'h800, 1023); chk("model_clamp_sw", b.instr, 32'h7E95AE23);
    chk("model_clamp_beats", 32'(n_beats(32'h3E85058B)), 32'd1024);

    // pass-through
    send(32'h00500093, 32'h100);
    chk("pt_valid", 32'(out_valid), 32'd1);
    chk("pt_instr", instr_out, 32'h00500093);
    chk("pt_pc", pc_out, 32'h100);
    chk("pt_last", 32'(uop_last), 32'd1);
    step();

    // MEMCPY x10 -> x11, N=2
    got.delete();
    send(32'h0025058B, 32'h200);
    repeat (6) step();
    chk("mc_count", 32'(got.size()), 32'd4);
    if (got.size() == 4) begin
      chk("mc_b0", got[0], 32'h00052483);
      chk("mc_b1", got[1], 32'h0095A023);
      chk("mc_b2", got[2], 32'h00452483);
      chk("mc_b3", got[3], 32'h0095A223);
    end

    // back-pressure on beat 2
    got.delete();
    send(32'h0025058B, 32'h300);
    step();
    out_ready = 1'b0;
    repeat (3) begin
      #1;
      chk("bp_hold", instr_out, 32'h0095A023);
      step();
    end
    out_ready = 1'b1;
    repeat (6) step();
    chk("bp_count", 32'(got.size()), 32'd4);
    if (got.size() == 4) chk("bp_b1", got[1], 32'h0095A023);

    // MEMSET value x5 -> dst x6, N=3
    got.delete();
    send(32'h0032930B, 32'h400);
    repeat (5) step();
    chk("ms_count", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      chk("ms_b0", got[0], 32'h00532023);
      chk("ms_b1", got[1], 32'h00532223);
      chk("ms_b2", got[2], 32'h00532423);
    end

    // zero-length macro
    got.delete();
    send(32'h0005058B, 32'h500);
    repeat (2) step();
    chk("n0_count", 32'(got.size()), 32'd1);
    if (got.size() == 1) chk("n0_nop", got[0], 32'h00000013);

    // flush during beat 3 of MEMCPY N=4
    send(32'h0045058B, 32'h600);
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_state", 32'(state), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    step();

    // reset mid-expansion
    send(32'h0045058B, 32'h700);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_state", 32'(state), 32'd0);
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    chk("mr_instr", instr_out, 32'h00000013);
    step();

    // clamp: N=1000 -> 512 words
    got.delete();
    send(32'h3E85058B, 32'h800);
    repeat (1030) step();
    chk("cl_count", 32'(got.size()), 32'd1024);
    if (got.size() == 1024) begin
      chk("cl_last_lw", got[1022], 32'h7FC52483);
      chk("cl_last_sw", got[1023], 32'h7E95AE23);
    end

    // randomized traffic
    repeat (4000) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      instr_in  = rand_instr();
      pc_in     = $urandom & 32'hFFFF_FFFC;
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 999) < 15);
      rst       = ($urandom_range(0, 999) < 3);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mi_expander.md
Name: mi_expander

Overview:
- Parametrised successor to the multicycle memcopy decoder. It sits between fetch and decode.
- Recognises custom macro instructions (MEMCPY, MEMSET) and expands each into a stream of RV32I LW/SW micro-ops.
- All other instructions pass through unchanged with one registered stage.
- Adds a valid/ready handshake, decode back-pressure, flush/abort, a zero-length case, count clamping and correct SW encoding.

Parameters:
- WIDTH, 32, instruction/PC width.
- MAX_WORDS, 512, maximum word count per macro; offsets 4*(MAX_WORDS-1) must fit a 12-bit signed immediate, so MAX_WORDS must be ≤512.
- SCRATCH_REG, 5'd9, register used as the LW destination and SW source for MEMCPY.
- CUSTOM_OPCODE, 7'b0001011, opcode identifying macro instructions.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline redirect; abort current expansion
- in_valid  in  1  fetch presents instr_in/pc_in
- in_ready  out  1  block accepts instr_in this cycle
- pc_in  in  WIDTH  PC of instr_in
- instr_in  in  WIDTH  fetched instruction
- pc_en  out  1  fetch PC advance enable; equals in_ready
- out_valid  out  1  instr_out/pc_out valid to decode
- out_ready  in  1  decode accepts output
- instr_out  out  WIDTH  passed-through instruction or micro-op
- pc_out  out  WIDTH  PC of the instruction; for micro-ops, PC of the parent macro
- uop_last  out  1  instr_out is the final micro-op of a macro (or a pass-through)
- busy  out  1  expansion in progress (state != IDLE)
- state  out  2  FSM state, for debug

Behaviour:
- All state updates on posedge clk. rst is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, instr_out=32'h00000013 (NOP), pc_out=0, uop_last=0, busy=0, idx=0.
- Macro format, identified by opcode==CUSTOM_OPCODE:
  - funct3=000 is MEMCPY: rs1=[19:15] source base, [11:7] destination base.
  - funct3=001 is MEMSET: [19:15] value register, [11:7] destination base.
  - N=[31:20] unsigned word count, clamped to MAX_WORDS when larger.
  - Other funct3 values with CUSTOM_OPCODE pass through unchanged.
- Micro-op encodings, with off=4*i (12 bits):
  - LW(i) = {off, src, 3'b010, SCRATCH_REG, 7'b0000011}.
  - SW(i) = {off[11:5], data, dst, 3'b010, off[4:0], 7'b0100011}; data=SCRATCH_REG for MEMCPY, value register for MEMSET.
- "Advance" means !out_valid || out_ready.
- in_ready = (state==IDLE) && advance && !flush.
- FSM states (2-bit, encoding IDLE=0, LOAD=1, STORE=2). The state names what is currently on the output.
- IDLE, on accept (in_valid && in_ready):
  - Pass-through: instr_out<=instr_in, pc_out<=pc_in, out_valid<=1, uop_last<=1.
  - MEMCPY, N>0: latch src/dst/N/pc; instr_out<=LW(0); ->LOAD.
  - MEMSET, N>0: instr_out<=SW(0); ->STORE; uop_last<=(N==1).
  - N==0: emit a single NOP with uop_last=1; stay IDLE.
- IDLE, no accept while advancing: out_valid<=0.
- LOAD, on advance: instr_out<=SW(idx); uop_last<=(idx==N-1); ->STORE.
- STORE, on advance:
  - If idx==N-1: out_valid<=0, ->IDLE.
  - Otherwise: idx<=idx+1; instr_out<=LW(idx+1) for MEMCPY or SW(idx+1) for MEMSET; next state LOAD or STORE respectively.
- Stall: while out_valid && !out_ready, all outputs and state hold, and in_ready=0.
- Micro-op count: MEMCPY emits 2N, MEMSET emits N, each beat lasting ≥1 cycle. A new instruction may be accepted in the cycle after the last SW is accepted.
- flush (any state, highest priority after rst): next cycle state=IDLE, out_valid=0, idx=0, no accept that cycle. An in-flight macro is discarded entirely.
- pc_en=in_ready. pc_out stays the macro PC for all of its micro-ops.
- idx is wide enough for MAX_WORDS-1. No wrap is possible because of the clamp.

Decomposition:
- Package mi_pkg holds:
  - state_t enum (IDLE, LOAD, STORE);
  - constants OP_LOAD, OP_STORE, F3_WORD, F3_MEMCPY, F3_MEMSET, NOP_INSTR;
  - functions enc_lw(off,rs1,rd) and enc_sw(off,rs2,rs1).
- Single module; no sub-module is needed. The encode functions live in the package.

Test Plan:
- Pass-through: addi 0x00500093 at pc 0x100, out_ready=1 -> next cycle out_valid=1, instr_out=0x00500093, pc_out=0x100, uop_last=1.
- MEMCPY with rs1=x10, rd=x11, N=2, out_ready=1 -> four beats 0x00052483, 0x0095A023, 0x00452483, 0x0095A223; pc_out constant; uop_last only on the 4th beat; in_ready=0 for those 4 cycles.
- MEMSET with value x5, dst x6, N=3 -> 0x00532023, 0x00532223, 0x00532423; then IDLE.
- Back-pressure: out_ready=0 for 3 cycles during MEMCPY beat 2 -> instr_out holds 0x0095A023 and no beat is lost or duplicated.
- N=0 macro -> single NOP 0x00000013 with uop_last=1; busy never asserted.
- Flush asserted during beat 3 of MEMCPY N=4, and rst asserted mid-expansion -> each gives next cycle out_valid=0, state=IDLE, in_ready=1.
- N=1000 -> clamped to 512; last SW offset 0x7FC; 1024 beats.
